// File: rtl/conv_pkg.sv
// Shared definitions for the image streaming front end and the Conv2D3x3 consumer:
// FSM state encoding and helpers for frame size and beat packing.
package conv_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } tx_state_e;

  function automatic int calc_wpt(input int width, input int word_width);
    return width / word_width;
  endfunction

  function automatic int calc_num_words(input int height, input int width, input int channel);
    return height * width * channel;
  endfunction

  function automatic int calc_num_beats(input int height, input int width, input int channel,
                                        input int beat_width, input int word_width);
    return calc_num_words(height, width, channel) / calc_wpt(beat_width, word_width);
  endfunction

endpackage

// File: rtl/image_word_buf.sv
// Frame buffer: one write port and a combinational read window of WPT consecutive words.
module image_word_buf #(
  parameter int NUM_WORDS  = 80,
  parameter int WORD_WIDTH = 8,
  parameter int WPT        = 2,
  parameter int PTR_W      = 7
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [PTR_W-1:0]          waddr_i,
  input  logic [WORD_WIDTH-1:0]     wdata_i,
  input  logic [PTR_W-1:0]          raddr_i,
  output logic [WPT*WORD_WIDTH-1:0] rdata_o
);

  logic [WORD_WIDTH-1:0] mem_q [NUM_WORDS];

  // Storage is deliberately not reset; contents are only meaningful after a full load.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar j = 0; j < WPT; j++) begin : g_window
    assign rdata_o[j*WORD_WIDTH +: WORD_WIDTH] = mem_q[raddr_i + PTR_W'(j)];
  end

endmodule

// File: rtl/image_stream_tx.sv
// Buffers one full image frame from a simple valid/ready load port, then replays it
// as WPT-word AXI-stream beats in channel/column/row raster order.
module image_stream_tx
  import conv_pkg::*;
#(
  parameter int IN_HEIGHT  = 5,
  parameter int IN_WIDTH   = 4,
  parameter int IN_CHANNEL = 4,
  parameter int WIDTH      = 16,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  i_aclk,
  input  logic                  i_aresetn,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [WORD_WIDTH-1:0] i_wr_data,
  input  logic                  i_flush,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [WIDTH-1:0]      o_tdata,
  output logic                  o_tlast,
  output logic                  o_frame_done
);

  localparam int WPT       = calc_wpt(WIDTH, WORD_WIDTH);
  localparam int NUM_WORDS = calc_num_words(IN_HEIGHT, IN_WIDTH, IN_CHANNEL);
  localparam int PTR_W     = $clog2(NUM_WORDS + 1);

  localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(NUM_WORDS - 1);
  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(NUM_WORDS - WPT);
  localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(WPT);

  if ((WIDTH % WORD_WIDTH) != 0 || (NUM_WORDS % WPT) != 0) begin : g_bad_params
    $error("image_stream_tx: beat width must hold a whole number of words and frame a whole number of beats");
  end

  tx_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             frame_done_q, frame_done_d;

  logic wr_hs_s;
  logic rd_hs_s;

  assign wr_hs_s = (state_q == FILL) && i_wr_valid;
  assign rd_hs_s = (state_q == STREAM) && i_tready;

  // Next-state logic; flush overrides any coincident load or beat handshake.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = 1'b0;
    if (i_flush) begin
      state_d  = FILL;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (wr_hs_s) begin
            if (wr_ptr_q == LAST_WORD) begin
              state_d  = STREAM;
              wr_ptr_d = '0;
              rd_ptr_d = '0;
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
          end else begin
            wr_ptr_d = wr_ptr_q;
          end
        end
        STREAM: begin
          if (rd_hs_s) begin
            if (rd_ptr_q == LAST_BEAT) begin
              state_d      = FILL;
              rd_ptr_d     = '0;
              frame_done_d = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + PTR_STEP;
            end
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end
        default: begin
          state_d  = FILL;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      endcase
    end
  end

  // State and pointer registers.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
    end
  end

  image_word_buf #(
    .NUM_WORDS  (NUM_WORDS),
    .WORD_WIDTH (WORD_WIDTH),
    .WPT        (WPT),
    .PTR_W      (PTR_W)
  ) u_buf (
    .clk_i   (i_aclk),
    .we_i    (wr_hs_s && !i_flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (o_tdata)
  );

  // Handshake outputs decode registered state only, so o_tvalid never follows i_tready.
  assign o_wr_ready   = (state_q == FILL);
  assign o_tvalid     = (state_q == STREAM);
  assign o_tlast      = (state_q == STREAM) && (rd_ptr_q == LAST_BEAT);
  assign o_frame_done = frame_done_q;

endmodule
